mem_wbuf: RTL and testbench
===========================

MEM_WBUF -- requirements
Module: mem_wbuf

Interface
REQ-001 Parameter DEPTH, default 4, store-buffer entries; power of two, >=2.
REQ-002 Parameter UNCACHED_ONLY, default 1; when 0, the buffer still drains in order but loads may bypass a non-empty buffer if no entry matches the word address.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_rd / req_wr  in  1 / 1  load / store request from the MEM stage, held stable while stall=1.
REQ-006 req_addr  in  32  byte address.
REQ-007 req_type  in  3  [1:0] 00 byte, 01 half, 10 word, 11 unaligned; [2] is sign-extend for byte/half and left(0)/right(1) for unaligned.
REQ-008 req_wdata  in  32  store source register value, unaligned.
REQ-009 req_kill  in  1  exception in flight; suppresses the access.
REQ-010 stall  out  1  pipeline hold.
REQ-011 rdata  out  32  aligned and extended load result.
REQ-012 rdata_we  out  4  register-file byte enables.
REQ-013 mem_req, mem_wr  out  1 / 1  SRAM-like request.
REQ-014 mem_addr  out  32  request address.
REQ-015 mem_wstrb  out  4  write byte strobes.
REQ-016 mem_wdata  out  32  write data.
REQ-017 mem_rdata  in  32  read data.
REQ-018 mem_addr_ok, mem_data_ok  in  1 / 1  slave handshakes.
REQ-019 wbuf_empty  out  1  high when the buffer holds no entries.

Function
REQ-020 Every bus access is word-sized: mem_addr = {req_addr[31:2],2'b00}, and mem_size is not generated.
REQ-021 Store lane mapping:
- sb: strb = 1<<a[1:0], byte replicated to all lanes.
- sh: strb 0011 or 1100, half replicated.
- sw: strb 1111.
- swl, offset 0..3: strb 0001, 0011, 0111, 1111; data = wdata>>(8*(3-off)).
- swr, offset 0..3: strb 1111, 1110, 1100, 1000; data = wdata<<(8*off).
REQ-022 A misaligned half/word access, or req_kill=1, performs no access, does not stall, and drives rdata_we=0000.
REQ-023 A valid store enqueues {addr, strb, data} in the cycle that stall=0; stall=1 while count==DEPTH, even if a dequeue happens in the same cycle.
REQ-024 Drain FSM states:
- W_IDLE to W_ADDR when not empty; drives mem_req=1, mem_wr=1 with the head entry.
- W_ADDR to W_DATA on mem_addr_ok.
- W_DATA to W_IDLE on mem_data_ok; the head is popped in the same cycle.
REQ-025 Load FSM states:
- R_IDLE to R_ADDR when req_rd is valid and the issue condition holds.
- R_ADDR to R_DATA on mem_addr_ok.
- R_DATA to R_IDLE on mem_data_ok.
REQ-026 Load issue condition: wbuf_empty=1 and drain in W_IDLE; with UNCACHED_ONLY=0, alternatively no entry word-address match and drain in W_IDLE.
REQ-027 Only one bus transaction is outstanding at a time; drain has priority when both FSMs are eligible in the same cycle.
REQ-028 Load stall is high from request until the mem_data_ok cycle inclusive of R_DATA evaluation; stall drops in that cycle, and rdata/rdata_we are valid combinationally from mem_rdata in that cycle.
REQ-029 Load extraction for lb/lbu/lh/lhu/lw: select the lane by a[1:0], sign- or zero-extend, rdata_we=1111.
REQ-030 lwl, offset 0..3: we 1000, 1100, 1110, 1111; rdata = m<<(8*(3-off)).
REQ-031 lwr, offset 0..3: we 1111, 0111, 0011, 0001; rdata = m>>(8*off).
REQ-032 FIFO pointers are log2(DEPTH)+1 bits with natural wrap; empty when pointers are equal, full when the MSB differs and the rest are equal.
REQ-033 Simultaneous enqueue and dequeue leaves count unchanged.

Reset
REQ-034 On rst, both FSMs go idle and pointers clear:
- stall=0, mem_req=0, mem_wr=0, mem_wstrb=0000, mem_addr=0, mem_wdata=0.
- rdata=0, rdata_we=0000, wbuf_empty=1.
REQ-035 Reset mid-transaction abandons the transaction; a mem_data_ok arriving after reset is ignored.

Verification
REQ-036 sb to 0xA0000003, wdata 0x12345678 -> one write, addr 0xA0000000, strb 1000, data 0x78787878; stall=0 throughout.
REQ-037 DEPTH=4, 5 back-to-back sw with addr_ok/data_ok withheld -> stall rises on the 5th store; bus stays at the first entry; after 1 data_ok the 5th enqueues.
REQ-038 sw 0x1 then lw, same address -> read issues only after the write data_ok; rdata=0x00000001, we=1111.
REQ-039 lwl offset 1, mem_rdata 0xAABBCCDD -> rdata[31:16]=0xCCDD, we 1100; lh offset 2 with signed type, same data -> 0xFFFFAABB.
REQ-040 rst asserted in R_DATA, then data_ok one cycle later -> all outputs at reset values and no rdata_we pulse.
REQ-041 lw to 0x...2, or req_kill=1 -> no mem_req, stall=0, rdata_we=0000.

Source files
------------

// File: rtl/mem_wbuf.sv
// MEM-stage load/store unit with an in-order store buffer in front of an SRAM-like bus.
// Stores are posted into a FIFO and drained one at a time; loads wait for the buffer unless bypass is legal.
module mem_wbuf #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned UNCACHED_ONLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_wdata,
  input  logic        req_kill,
  output logic        stall,
  output logic [31:0] rdata,
  output logic [3:0]  rdata_we,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  output logic        wbuf_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {WIdle, WAddr, WData} wr_st_e;
  typedef enum logic [1:0] {RIdle, RAddr, RData} rd_st_e;

  wr_st_e r_wr_st, w_wr_nxt;
  rd_st_e r_rd_st, w_rd_nxt;

  logic [PW-1:0] r_wptr, r_rptr;
  logic [29:0]   r_fa [DEPTH];
  logic [3:0]    r_fs [DEPTH];
  logic [31:0]   r_fd [DEPTH];

  logic [1:0]    w_off, w_sz;
  logic          w_ext, w_misalign, w_ok, w_ld, w_st;
  logic [4:0]    w_lsh, w_rsh;
  logic [3:0]    w_st_strb;
  logic [31:0]   w_st_data;
  logic [15:0]   w_lane;
  logic [31:0]   w_ld_data;
  logic [3:0]    w_ld_we;
  logic          w_ld_done;
  logic [PW-1:0] w_cnt;
  logic          w_empty, w_full, w_enq, w_pop, w_match;
  logic          w_drain_go, w_issue;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign w_off      = req_addr[1:0];
  assign w_sz       = req_type[1:0];
  assign w_ext      = req_type[2];
  assign w_misalign = ((w_sz == 2'b01) && w_off[0]) || ((w_sz == 2'b10) && (w_off != 2'b00));
  assign w_ok       = !req_kill && !w_misalign;
  assign w_ld       = req_rd && w_ok;
  assign w_st       = req_wr && w_ok;
  assign w_lsh      = {w_off, 3'b000};
  // 8*(3-off): for a 2-bit offset, 3-off is simply its complement
  assign w_rsh      = {~w_off, 3'b000};

  always_comb begin
    w_st_strb = 4'b0000;
    w_st_data = 32'h0;
    unique case (w_sz)
      2'b00: begin
        w_st_strb = 4'b0001 << w_off;
        w_st_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_st_strb = w_off[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        w_st_strb = 4'b1111;
        w_st_data = req_wdata;
      end
      2'b11: begin
        if (!w_ext) begin
          w_st_strb = 4'b1111 >> ~w_off;
          w_st_data = req_wdata >> w_rsh;
        end else begin
          w_st_strb = 4'b1111 << w_off;
          w_st_data = req_wdata << w_lsh;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction
  // ---------------------------------------------------------------------------
  assign w_lane = 16'(mem_rdata >> w_lsh);

  always_comb begin
    w_ld_data = 32'h0;
    w_ld_we   = 4'b1111;
    unique case (w_sz)
      2'b00: w_ld_data = {{24{w_ext & w_lane[7]}}, w_lane[7:0]};
      2'b01: w_ld_data = {{16{w_ext & w_lane[15]}}, w_lane[15:0]};
      2'b10: w_ld_data = mem_rdata;
      2'b11: begin
        if (!w_ext) begin
          w_ld_data = mem_rdata << w_rsh;
          w_ld_we   = 4'b1111 << ~w_off;
        end else begin
          w_ld_data = mem_rdata >> w_lsh;
          w_ld_we   = 4'b1111 >> w_off;
        end
      end
      default: ;
    endcase
  end

  assign w_ld_done = (r_rd_st == RData) && mem_data_ok && w_ld;
  assign rdata     = w_ld_done ? w_ld_data : 32'h0;
  assign rdata_we  = w_ld_done ? w_ld_we : 4'b0000;

  // ---------------------------------------------------------------------------
  // Store FIFO
  // ---------------------------------------------------------------------------
  assign w_cnt   = r_wptr - r_rptr;
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_enq   = w_st && !w_full;
  assign w_pop   = (r_wr_st == WData) && mem_data_ok;

  assign wbuf_empty = w_empty;
  // A full buffer stalls even when the head pops this cycle; the store enqueues next cycle.
  assign stall      = (w_st && w_full) || (w_ld && !w_ld_done);

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fa[r_wptr[AW-1:0]] <= req_addr[31:2];
      r_fs[r_wptr[AW-1:0]] <= w_st_strb;
      r_fd[r_wptr[AW-1:0]] <= w_st_data;
    end
  end

  // Word-address hit against any occupied entry, measured from the read pointer
  always_comb begin
    w_match = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (({1'b0, AW'(AW'(i) - r_rptr[AW-1:0])} < w_cnt) &&
          (r_fa[AW'(i)] == req_addr[31:2])) begin
        w_match = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drain and load FSMs; one shared bus, drain wins ties
  // ---------------------------------------------------------------------------
  assign w_drain_go = !w_empty && (r_rd_st == RIdle);
  assign w_issue    = w_ld && (r_rd_st == RIdle) && (r_wr_st == WIdle) && !w_drain_go &&
                      (w_empty || ((UNCACHED_ONLY == 0) && !w_match));

  always_comb begin
    w_wr_nxt  = r_wr_st;
    w_rd_nxt  = r_rd_st;
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 32'h0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'h0;

    case (r_wr_st)
      WIdle: if (w_drain_go) w_wr_nxt = WAddr;
      WAddr: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {r_fa[r_rptr[AW-1:0]], 2'b00};
        mem_wstrb = r_fs[r_rptr[AW-1:0]];
        mem_wdata = r_fd[r_rptr[AW-1:0]];
        if (mem_addr_ok) w_wr_nxt = WData;
      end
      WData: if (mem_data_ok) w_wr_nxt = WIdle;
      default: w_wr_nxt = WIdle;
    endcase

    case (r_rd_st)
      RIdle: if (w_issue) w_rd_nxt = RAddr;
      RAddr: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr[31:2], 2'b00};
        if (mem_addr_ok) w_rd_nxt = RData;
      end
      RData: if (mem_data_ok) w_rd_nxt = RIdle;
      default: w_rd_nxt = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_st <= WIdle;
      r_rd_st <= RIdle;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_wr_st <= w_wr_nxt;
      r_rd_st <= w_rd_nxt;
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_wbuf.sv
// Directed bench for mem_wbuf: store lanes, buffer full, read-after-write, load extraction, reset.
module tb_mem_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_rd, req_wr, req_kill;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_type;
  logic        stall;
  logic [31:0] rdata;
  logic [3:0]  rdata_we;
  logic        mem_req, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        wbuf_empty;

  int checks = 0;
  int errors = 0;
  int n_wr_acc = 0;
  int n_rd_acc = 0;

  mem_wbuf #(.DEPTH(4), .UNCACHED_ONLY(1)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_type(req_type), .req_wdata(req_wdata), .req_kill(req_kill), .stall(stall),
    .rdata(rdata), .rdata_we(rdata_we), .mem_req(mem_req), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && mem_req && mem_addr_ok) begin
      if (mem_wr) n_wr_acc++;
      else n_rd_acc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_rd = 0; req_wr = 0; req_kill = 0; req_addr = 0; req_type = 0; req_wdata = 0;
    mem_rdata = 0; mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  // Waits for the next write request, captures it, then completes the handshake.
  task automatic drain_one(output logic [31:0] a, output logic [3:0] s, output logic [31:0] d,
                           output bit to);
    to = 1'b1;
    for (int i = 0; i < 20 && to; i++) begin
      #1;
      if (mem_req && mem_wr) to = 1'b0;
      else tick();
    end
    a = mem_addr; s = mem_wstrb; d = mem_wdata;
    if (!to) begin
      mem_addr_ok = 1; tick(); mem_addr_ok = 0;
      mem_data_ok = 1; tick(); mem_data_ok = 0;
    end
  endtask

  // Issues a load, answers it with m, and captures the result in the data_ok cycle.
  task automatic do_load(input logic [31:0] a, input logic [2:0] t, input logic [31:0] m,
                         output logic [31:0] rd, output logic [3:0] we, output logic st,
                         output bit to);
    req_rd = 1; req_addr = a; req_type = t; to = 1'b1;
    for (int i = 0; i < 20 && to; i++) begin
      #1;
      if (mem_req && !mem_wr) to = 1'b0;
      else tick();
    end
    rd = 0; we = 0; st = 1;
    if (!to) begin
      mem_addr_ok = 1; tick(); mem_addr_ok = 0;
      mem_data_ok = 1; mem_rdata = m; #1;
      rd = rdata; we = rdata_we; st = stall;
      tick(); mem_data_ok = 0;
    end
    req_rd = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs(); tick(); tick(); rst = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", stall); end
    checks++; if (mem_req !== 1'b0 || mem_wr !== 1'b0) begin errors++;
      $display("FAIL rst_req got %b%b want 00", mem_req, mem_wr); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin errors++;
      $display("FAIL rst_bus got %h %h %b want 0", mem_addr, mem_wdata, mem_wstrb); end
    checks++; if (rdata !== 32'h0 || rdata_we !== 4'h0) begin errors++;
      $display("FAIL rst_rdata got %h %b want 0", rdata, rdata_we); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", wbuf_empty); end
  endtask

  task automatic test_sb();
    logic [31:0] a, d; logic [3:0] s; bit to; int w0;
    w0 = n_wr_acc;
    req_wr = 1; req_addr = 32'hA000_0003; req_type = 3'b000; req_wdata = 32'h1234_5678; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_stall got %b want 0", stall); end
    tick(); req_wr = 0; #1;
    checks++; if (wbuf_empty !== 1'b0) begin errors++; $display("FAIL sb_enq got %b want 0", wbuf_empty); end
    drain_one(a, s, d, to);
    checks++; if (to || a !== 32'hA000_0000 || s !== 4'b1000 || d !== 32'h7878_7878) begin errors++;
      $display("FAIL sb_bus got to=%0d %h %b %h want A0000000 1000 78787878", to, a, s, d); end
    #1;
    checks++; if (n_wr_acc - w0 !== 1 || wbuf_empty !== 1'b1) begin errors++;
      $display("FAIL sb_count got %0d empty=%b want 1 1", n_wr_acc - w0, wbuf_empty); end
  endtask

  task automatic test_store_lanes();
    logic [31:0] a, d; logic [3:0] s; bit to;
    logic [31:0] ad [3] = '{32'h0000_0602, 32'h0000_0611, 32'h0000_0623};
    logic [2:0]  ty [3] = '{3'b001, 3'b011, 3'b111};
    logic [31:0] wd [3] = '{32'h0000_BEEF, 32'h1122_3344, 32'h1122_3344};
    logic [31:0] ea [3] = '{32'h0000_0600, 32'h0000_0610, 32'h0000_0620};
    logic [3:0]  es [3] = '{4'b1100, 4'b0011, 4'b1000};
    logic [31:0] ed [3] = '{32'hBEEF_BEEF, 32'h0000_1122, 32'h4400_0000};
    for (int k = 0; k < 3; k++) begin
      req_wr = 1; req_addr = ad[k]; req_type = ty[k]; req_wdata = wd[k];
      tick(); req_wr = 0;
      drain_one(a, s, d, to);
      checks++; if (to || a !== ea[k] || s !== es[k] || d !== ed[k]) begin errors++;
        $display("FAIL lane%0d got to=%0d %h %b %h want %h %b %h", k, to, a, s, d, ea[k], es[k], ed[k]);
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] a, d; logic [3:0] s; bit to;
    for (int k = 0; k < 4; k++) begin
      req_wr = 1; req_addr = 32'h100 + 32'(4 * k); req_type = 3'b010; req_wdata = 32'(k); #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_st%0d got %b want 0", k, stall); end
      tick();
    end
    req_addr = 32'h110; req_wdata = 32'h4; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b want 1", stall); end
    tick(); tick(); #1;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'h0)
      begin errors++; $display("FAIL full_hold got %b %b %h %h want 1 1 00000100 0", stall, mem_req,
        mem_addr, mem_wdata); end
    mem_addr_ok = 1; tick(); mem_addr_ok = 0; mem_data_ok = 1; #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL full_popcyc got %b want 1", stall); end
    tick(); mem_data_ok = 0; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL full_release got %b want 0", stall); end
    tick(); req_wr = 0;
    for (int k = 1; k < 5; k++) begin
      drain_one(a, s, d, to);
      checks++; if (to || a !== 32'h100 + 32'(4 * k) || s !== 4'b1111 || d !== 32'(k)) begin errors++;
        $display("FAIL full_drain%0d got to=%0d %h %b %h", k, to, a, s, d); end
    end
    #1;
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL full_empty got %b want 1", wbuf_empty); end
  endtask

  task automatic test_raw();
    int r0;
    req_wr = 1; req_addr = 32'h200; req_type = 3'b010; req_wdata = 32'h1; #1;
    tick(); req_wr = 0; req_rd = 1; r0 = n_rd_acc; #1;
    checks++; if (stall !== 1'b1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL raw_wait got %b %b want 1 0", stall, mem_req); end
    tick(); #1;
    checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b1) begin errors++;
      $display("FAIL raw_wrfirst got %b %b want 1 1", mem_req, mem_wr); end
    mem_addr_ok = 1; tick(); mem_addr_ok = 0; mem_data_ok = 1; tick(); mem_data_ok = 0; #1;
    checks++; if (n_rd_acc !== r0 || stall !== 1'b1) begin errors++;
      $display("FAIL raw_noread got %0d %b want %0d 1", n_rd_acc, stall, r0); end
    tick(); #1;
    checks++; if (mem_req !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 32'h200) begin errors++;
      $display("FAIL raw_rd got %b %b %h want 1 0 00000200", mem_req, mem_wr, mem_addr); end
    mem_addr_ok = 1; tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h1; #1;
    checks++; if (stall !== 1'b0 || rdata !== 32'h1 || rdata_we !== 4'b1111) begin errors++;
      $display("FAIL raw_data got %b %h %b want 0 00000001 1111", stall, rdata, rdata_we); end
    tick(); mem_data_ok = 0; req_rd = 0; #1;
    checks++; if (rdata_we !== 4'b0000) begin errors++; $display("FAIL raw_weclr got %b want 0000", rdata_we); end
  endtask

  task automatic test_load_extract();
    logic [31:0] rd; logic [3:0] we; logic st; bit to;
    logic [31:0] ad [5] = '{32'h301, 32'h302, 32'h303, 32'h302, 32'h300};
    logic [2:0]  ty [5] = '{3'b011, 3'b101, 3'b000, 3'b111, 3'b100};
    logic [31:0] er [5] = '{32'hCCDD_0000, 32'hFFFF_AABB, 32'h0000_00AA, 32'h0000_AABB,
                            32'hFFFF_FFDD};
    logic [3:0]  ew [5] = '{4'b1100, 4'b1111, 4'b1111, 4'b0011, 4'b1111};
    for (int k = 0; k < 5; k++) begin
      do_load(ad[k], ty[k], 32'hAABB_CCDD, rd, we, st, to);
      checks++; if (to || st !== 1'b0 || rd !== er[k] || we !== ew[k]) begin errors++;
        $display("FAIL ld%0d got to=%0d st=%b %h %b want 0 %h %b", k, to, st, rd, we, er[k], ew[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    req_rd = 1; req_addr = 32'h400; req_type = 3'b010; tick(); #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rm_issue got %b want 1", mem_req); end
    mem_addr_ok = 1; tick(); mem_addr_ok = 0;
    rst = 1; req_rd = 0; tick(); rst = 0;
    mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; #1;
    checks++; if (rdata_we !== 4'b0000 || rdata !== 32'h0 || stall !== 1'b0) begin errors++;
      $display("FAIL rm_out got %b %h %b want 0000 0 0", rdata_we, rdata, stall); end
    checks++; if (mem_req !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'h0 || wbuf_empty !== 1'b1)
      begin errors++; $display("FAIL rm_bus got %b %b %h %b want 0 0 0 1", mem_req, mem_wr,
        mem_addr, wbuf_empty); end
    tick(); mem_data_ok = 0; #1;
    checks++; if (mem_req !== 1'b0 || rdata_we !== 4'b0000) begin errors++;
      $display("FAIL rm_after got %b %b want 0 0000", mem_req, rdata_we); end
  endtask

  task automatic test_noaccess();
    logic [31:0] ad [3] = '{32'h502, 32'h501, 32'h500};
    logic [2:0]  ty [3] = '{3'b010, 3'b001, 3'b010};
    logic        kl [3] = '{1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      req_rd = 1; req_addr = ad[k]; req_type = ty[k]; req_kill = kl[k]; #1;
      checks++; if (stall !== 1'b0 || rdata_we !== 4'b0000) begin errors++;
        $display("FAIL na%0d_now got %b %b want 0 0000", k, stall, rdata_we); end
      tick(); tick(); #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL na%0d_req got %b want 0", k, mem_req); end
      req_rd = 0;
    end
    req_wr = 1; req_addr = 32'h500; req_type = 3'b010; req_kill = 1; tick(); tick(); #1;
    checks++; if (wbuf_empty !== 1'b1 || mem_req !== 1'b0) begin errors++;
      $display("FAIL na_killst got %b %b want 1 0", wbuf_empty, mem_req); end
    req_wr = 0; req_kill = 0;
  endtask

  initial begin
    test_reset();
    test_sb();
    test_store_lanes();
    test_full();
    test_raw();
    test_load_extract();
    test_reset_mid();
    test_noaccess();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
